alu_pipe: RTL and testbench

Fully pipelined, parametrised arithmetic/logic unit for the RMT action engine. It takes one sub-action and two operands per cycle and writes one result container per cycle back into the PHV assembly path. It replaces the earlier three-cycle, non-pipelined ALU: it sustains back-to-back actions, has configurable latency and width, adds immediate and logic opcodes, and can optionally saturate.

---
 rtl/alu_pipe.sv | 168 ++++++++++++++++
 tb/tb_alu_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: fully pipelined ALU for the RMT action engine, one action in and one result out per cycle.
// Optional feature: define ALU_SAT_EN for saturating add/sub with sat_flag_out; otherwise arithmetic wraps.
module alu_pipe #(
    parameter int STAGE      = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48,
    parameter int IMM_WIDTH  = 16,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    output logic [DATA_WIDTH-1:0] container_out,
    output logic                  container_out_valid,
    output logic                  sat_flag_out
);

    localparam logic [3:0] OP_ADD     = 4'b0001;
    localparam logic [3:0] OP_SUB     = 4'b0010;
    localparam logic [3:0] OP_ADDI    = 4'b0011;
    localparam logic [3:0] OP_SUBI    = 4'b0100;
    localparam logic [3:0] OP_AND     = 4'b0101;
    localparam logic [3:0] OP_OR      = 4'b0110;
    localparam logic [3:0] OP_XOR     = 4'b0111;
    localparam logic [3:0] OP_SET     = 4'b1000;
    localparam logic [3:0] OP_ADD_ALT = 4'b1001;
    localparam logic [3:0] OP_SUB_ALT = 4'b1010;

    logic [3:0]            opcode;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] arith_b;
    logic [DATA_WIDTH-1:0] logic_res;
    logic                  is_add;
    logic                  is_sub;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_sat;

    assign opcode = action_in[ACTION_LEN-1 -: 4];
    assign imm    = DATA_WIDTH'(action_in[IMM_WIDTH-1:0]);

    // Decode: select the second arithmetic operand and precompute the non-arithmetic result.
    always_comb begin
        arith_b   = operand_2_in;
        is_add    = 1'b0;
        is_sub    = 1'b0;
        logic_res = operand_1_in;
        case (opcode)
            OP_ADD, OP_ADD_ALT: is_add = 1'b1;
            OP_SUB, OP_SUB_ALT: is_sub = 1'b1;
            OP_ADDI: begin
                is_add  = 1'b1;
                arith_b = imm;
            end
            OP_SUBI: begin
                is_sub  = 1'b1;
                arith_b = imm;
            end
            OP_AND:  logic_res = operand_1_in & operand_2_in;
            OP_OR:   logic_res = operand_1_in | operand_2_in;
            OP_XOR:  logic_res = operand_1_in ^ operand_2_in;
            OP_SET:  logic_res = imm;
            default: logic_res = operand_1_in;
        endcase
    end

    assign diff = operand_1_in - arith_b;

`ifdef ALU_SAT_EN
    logic [DATA_WIDTH:0] sum_w;
    logic                carry;
    logic                borrow;

    assign sum_w  = {1'b0, operand_1_in} + {1'b0, arith_b};
    assign carry  = sum_w[DATA_WIDTH];
    assign borrow = (operand_1_in < arith_b);

    always_comb begin
        alu_res = logic_res;
        alu_sat = 1'b0;
        if (is_add) begin
            alu_res = sum_w[DATA_WIDTH-1:0];
            if (carry) begin
                alu_res = '1;
                alu_sat = 1'b1;
            end
        end else if (is_sub) begin
            alu_res = diff;
            if (borrow) begin
                alu_res = '0;
                alu_sat = 1'b1;
            end
        end
    end
`else
    logic [DATA_WIDTH-1:0] sum_w;

    assign sum_w = operand_1_in + arith_b;

    always_comb begin
        alu_res = logic_res;
        alu_sat = 1'b0;
        if (is_add) begin
            alu_res = sum_w;
        end else if (is_sub) begin
            alu_res = diff;
        end
    end
`endif

    logic                  vld_q [LATENCY];
    logic                  sat_q [LATENCY];
    logic [DATA_WIDTH-1:0] res_q [LATENCY];

    // Each stage forwards valid every cycle but only captures data on a valid beat, so the
    // last stage holds the previous result between strobes.
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic                  in_vld;
            logic                  in_sat;
            logic [DATA_WIDTH-1:0] in_res;
            logic                  vld_d;
            logic                  sat_d;
            logic [DATA_WIDTH-1:0] res_d;

            if (gi == 0) begin : g_head
                assign in_vld = action_valid;
                assign in_sat = alu_sat;
                assign in_res = alu_res;
            end else begin : g_tail
                assign in_vld = vld_q[gi-1];
                assign in_sat = sat_q[gi-1];
                assign in_res = res_q[gi-1];
            end

            always_comb begin
                vld_d = in_vld;
                sat_d = sat_q[gi];
                res_d = res_q[gi];
                if (in_vld) begin
                    sat_d = in_sat;
                    res_d = in_res;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q[gi] <= 1'b0;
                    sat_q[gi] <= 1'b0;
                    res_q[gi] <= '0;
                end else begin
                    vld_q[gi] <= vld_d;
                    sat_q[gi] <= sat_d;
                    res_q[gi] <= res_d;
                end
            end
        end
    endgenerate

    assign container_out       = res_q[LATENCY-1];
    assign container_out_valid = vld_q[LATENCY-1];
    assign sat_flag_out        = sat_q[LATENCY-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe: hand-computed results, strobe timing and ordering via an expectation queue.
module tb_alu_pipe;
    localparam int ACTION_LEN = 25;
    localparam int DATA_WIDTH = 48;
    localparam int IMM_WIDTH  = 16;
    localparam int LAT        = 3;
`ifdef ALU_SAT_EN
    localparam bit SATB = 1'b1;
`else
    localparam bit SATB = 1'b0;
`endif
    localparam logic [47:0] ALL1 = 48'hFFFF_FFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [ACTION_LEN-1:0] action_in = '0;
    logic                  action_valid = 1'b0;
    logic [DATA_WIDTH-1:0] operand_1_in = '0;
    logic [DATA_WIDTH-1:0] operand_2_in = '0;
    logic [DATA_WIDTH-1:0] container_out;
    logic                  container_out_valid;
    logic                  sat_flag_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [47:0] val;
        logic        sat;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    alu_pipe #(
        .STAGE(0), .ACTION_LEN(ACTION_LEN), .DATA_WIDTH(DATA_WIDTH),
        .IMM_WIDTH(IMM_WIDTH), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .action_in(action_in), .action_valid(action_valid),
        .operand_1_in(operand_1_in), .operand_2_in(operand_2_in),
        .container_out(container_out), .container_out_valid(container_out_valid),
        .sat_flag_out(sat_flag_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [ACTION_LEN-1:0] make_action(input logic [3:0] op, input logic [15:0] im);
        logic [ACTION_LEN-1:0] a;
        a        = '0;
        a[24:21] = op;
        a[20:16] = 5'h15;
        a[15:0]  = im;
        return a;
    endfunction

    // Present garbage on the data inputs so idle cycles prove they are ignored.
    task automatic scramble();
        action_valid = 1'b0;
        action_in    = ACTION_LEN'($urandom);
        operand_1_in = {16'($urandom), 32'($urandom)};
        operand_2_in = {16'($urandom), 32'($urandom)};
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] im, input logic [47:0] a,
                        input logic [47:0] b, input logic [47:0] ev, input logic es, input bit track);
        exp_t e;
        action_in    = make_action(op, im);
        operand_1_in = a;
        operand_2_in = b;
        action_valid = 1'b1;
        if (track) begin
            e.val = ev;
            e.sat = es;
            e.cyc = cyc + LAT;
            exp_q.push_back(e);
        end
        $display("send op=%b imm=%h op1=%h op2=%h exp=%h sat=%0b", op, im, a, b, ev, es);
        @(posedge clk);
        #1;
        scramble();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            scramble();
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && container_out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_strobe", 64'(container_out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("strobe cycle=%0d out=%h sat=%0b", cyc, container_out, sat_flag_out);
                check("result", 64'(container_out), 64'(e.val));
                check("sat_flag", 64'(sat_flag_out), 64'(e.sat));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(container_out_valid), 64'd0);
        check("reset_out", 64'(container_out), 64'd0);
        check("reset_sat", 64'(sat_flag_out), 64'd0);
        rst = 1'b0;

        // Single add, then the output must hold 12 with valid low.
        send(4'b0001, 16'h0, 48'd5, 48'd7, 48'd12, 1'b0, 1'b1);
        idle(LAT + 2);
        check("hold_out", 64'(container_out), 64'd12);
        check("hold_valid", 64'(container_out_valid), 64'd0);

        // Back-to-back stream.
        send(4'b0011, 16'h0010, 48'h1, 48'h777, 48'h11, 1'b0, 1'b1);
        send(4'b0100, 16'h0001, 48'h20, 48'h555, 48'h1F, 1'b0, 1'b1);
        send(4'b0111, 16'h0, 48'hF0, 48'h0F, 48'hFF, 1'b0, 1'b1);
        send(4'b1000, 16'hABCD, 48'h999, 48'h888, 48'hABCD, 1'b0, 1'b1);

        // Overflow / underflow boundaries, wrap or clamp depending on build.
        send(4'b0001, 16'h0, ALL1, 48'd2, SATB ? ALL1 : 48'd1, SATB, 1'b1);
        send(4'b0010, 16'h0, 48'd0, 48'd1, SATB ? 48'd0 : ALL1, SATB, 1'b1);
        send(4'b0001, 16'h0, 48'd3, 48'd4, 48'd7, 1'b0, 1'b1);
        send(4'b0011, 16'h0001, ALL1, 48'd0, SATB ? ALL1 : 48'd0, SATB, 1'b1);
        send(4'b0100, 16'h0005, 48'd0, 48'd0, SATB ? 48'd0 : 48'hFFFF_FFFF_FFFB, SATB, 1'b1);
        send(4'b0010, 16'h0, 48'd9, 48'd9, 48'd0, 1'b0, 1'b1);

        // Alias opcodes, logic ops, pass-through.
        send(4'b1001, 16'h0, 48'd10, 48'd20, 48'd30, 1'b0, 1'b1);
        send(4'b1010, 16'h0, 48'd50, 48'd8, 48'd42, 1'b0, 1'b1);
        send(4'b0101, 16'h0, 48'hF0F0, 48'h0FF0, 48'h00F0, 1'b0, 1'b1);
        send(4'b0110, 16'h0, 48'hF000, 48'h000F, 48'hF00F, 1'b0, 1'b1);
        send(4'b0000, 16'hFFFF, 48'h55, 48'h66, 48'h55, 1'b0, 1'b1);
        idle(2);

        // Unknown opcode and a 1,0,1 valid pattern.
        send(4'b1111, 16'h0, 48'h1234, 48'h9999, 48'h1234, 1'b0, 1'b1);
        idle(1);
        send(4'b0001, 16'h0, 48'h100, 48'h23, 48'h123, 1'b0, 1'b1);
        idle(LAT + 2);
        check("queue_before_reset", 64'(exp_q.size()), 64'd0);

        // Two in-flight actions dropped by a reset pulse.
        send(4'b0001, 16'h0, 48'd1, 48'd1, 48'd2, 1'b0, 1'b0);
        send(4'b0001, 16'h0, 48'd2, 48'd2, 48'd4, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(container_out_valid), 64'd0);
        check("rst_async_out", 64'(container_out), 64'd0);
        check("rst_async_sat", 64'(sat_flag_out), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(LAT + 3);
        check("post_rst_out", 64'(container_out), 64'd0);
        send(4'b0001, 16'h0, 48'd1, 48'd2, 48'd3, 1'b0, 1'b1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
